// File: rtl/conductance_decay_unit.sv
// rtl/conductance_decay_unit.sv - conductance update g - g*DeltaT/Tau + sum(weights), serial restoring divider
module conductance_decay_unit #(
    parameter int INTEGER_WIDTH   = 16,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic signed [DATA_WIDTH-1:0]    g_in_i,
    input  logic signed [INTEGER_WIDTH-1:0] tau_i,
    input  logic        [DELTAT_WIDTH-1:0]  delta_t_i,
    input  logic                            weight_valid_i,
    input  logic signed [DATA_WIDTH-1:0]    weight_i,
    output logic signed [DATA_WIDTH-1:0]    g_out_o,
    output logic                            done_o,
    output logic                            busy_o,
    output logic                            div_by_zero_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int CNT_W  = $clog2(DATA_WIDTH);
    localparam int PROD_W = DATA_WIDTH + DELTAT_WIDTH;
    localparam int REM_W  = INTEGER_WIDTH + 1;

    logic [1:0]                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0]   g_q, g_d;
    logic signed [INTEGER_WIDTH-1:0] tau_q, tau_d;
    logic [DELTAT_WIDTH-1:0]        dt_q, dt_d;
    logic signed [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [INTEGER_WIDTH-1:0]       rem_q, rem_d;
    logic [DATA_WIDTH-1:0]          dvd_q, dvd_d;
    logic                           neg_q, neg_d;
    logic                           skip_q, skip_d;
    logic signed [DATA_WIDTH-1:0]   g_out_q, g_out_d;
    logic                           done_q, done_d;
    logic                           busy_q, busy_d;
    logic                           dbz_q, dbz_d;

    logic signed [PROD_W-1:0]       prod;
    logic signed [DATA_WIDTH-1:0]   decay;
    logic [REM_W-1:0]               trial;
    logic [REM_W-1:0]               tau_ext;
    logic [REM_W-1:0]               rem_step;
    logic                           q_bit;
    logic [DATA_WIDTH-1:0]          dvd_step;
    logic signed [DATA_WIDTH-1:0]   quot;

    // Multiplying by the raw DeltaT and shifting right by its width selects the
    // same bits as the full product with the zero-padded Q16.32 DeltaT.
    assign prod  = $signed({{DELTAT_WIDTH{g_q[DATA_WIDTH-1]}}, g_q})
                 * $signed({{DATA_WIDTH{1'b0}}, dt_q});
    assign decay = DATA_WIDTH'(prod >>> DELTAT_WIDTH);

    // Remainder always stays below Tau, so one extra bit covers the trial value.
    assign trial    = {rem_q, dvd_q[DATA_WIDTH-1]};
    assign tau_ext  = {1'b0, tau_q};
    assign q_bit    = (trial >= tau_ext);
    assign rem_step = q_bit ? (trial - tau_ext) : trial;
    assign dvd_step = {dvd_q[DATA_WIDTH-2:0], q_bit};

    always_comb begin
        quot = '0;
        if (!skip_q) begin
            quot = neg_q ? -$signed(dvd_step) : $signed(dvd_step);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        tau_d   = tau_q;
        dt_d    = dt_q;
        acc_d   = weight_valid_i ? (acc_q + weight_i) : acc_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        neg_d   = neg_q;
        skip_d  = skip_q;
        g_out_d = g_out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    g_d     = g_in_i;
                    tau_d   = tau_i;
                    dt_d    = delta_t_i;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = MULT;
                end
            end
            MULT: begin
                neg_d   = decay[DATA_WIDTH-1];
                dvd_d   = decay[DATA_WIDTH-1] ? DATA_WIDTH'(-decay) : DATA_WIDTH'(decay);
                rem_d   = '0;
                cnt_d   = '0;
                skip_d  = (tau_q <= 0);
                state_d = DIV;
            end
            DIV: begin
                if (!skip_q) begin
                    rem_d = INTEGER_WIDTH'(rem_step);
                    dvd_d = dvd_step;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    // Weight arriving on this edge starts the next update's sum.
                    g_out_d = g_q - quot + acc_q;
                    acc_d   = weight_valid_i ? weight_i : '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    dbz_d   = skip_q;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g_q     <= '0;
            tau_q   <= '0;
            dt_q    <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            neg_q   <= 1'b0;
            skip_q  <= 1'b0;
            g_out_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            tau_q   <= tau_d;
            dt_q    <= dt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            neg_q   <= neg_d;
            skip_q  <= skip_d;
            g_out_q <= g_out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            dbz_q   <= dbz_d;
        end
    end

    assign g_out_o       = g_out_q;
    assign done_o        = done_q;
    assign busy_o        = busy_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_conductance_decay_unit.sv
// tb/tb_conductance_decay_unit.sv - directed self-checking bench for conductance_decay_unit
module tb_conductance_decay_unit;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [47:0] g_in;
    logic signed [15:0] tau;
    logic        [3:0]  delta_t;
    logic               weight_valid;
    logic signed [47:0] weight;
    logic signed [47:0] g_out;
    logic               done;
    logic               busy;
    logic               dbz;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conductance_decay_unit dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .g_in_i         (g_in),
        .tau_i          (tau),
        .delta_t_i      (delta_t),
        .weight_valid_i (weight_valid),
        .weight_i       (weight),
        .g_out_o        (g_out),
        .done_o         (done),
        .busy_o         (busy),
        .div_by_zero_o  (dbz)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one update from its Start edge (edge 0) through edge 50, with up to
    // three weights placed on chosen edges (-1 = unused).
    task automatic run_update(input string tag, input logic [47:0] g, input logic [15:0] t,
                              input logic [3:0] dt,
                              input int ea, input logic [47:0] wa,
                              input int eb, input logic [47:0] wb,
                              input int ec, input logic [47:0] wc,
                              input logic [47:0] exp_g, input logic exp_dbz);
        for (int e = 0; e <= 50; e++) begin
            start        = (e == 0);
            g_in         = g;
            tau          = t;
            delta_t      = dt;
            weight_valid = 1'b0;
            weight       = '0;
            if (e == ea) begin weight_valid = 1'b1; weight = wa; end
            if (e == eb) begin weight_valid = 1'b1; weight = wb; end
            if (e == ec) begin weight_valid = 1'b1; weight = wc; end
            tick();
            start        = 1'b0;
            weight_valid = 1'b0;
            if (e <= 48) begin
                check($sformatf("%s busy e%0d", tag, e), 48'(busy), 48'd1);
                check($sformatf("%s done e%0d", tag, e), 48'(done), 48'd0);
            end else if (e == 49) begin
                check($sformatf("%s done e49", tag), 48'(done), 48'd1);
                check($sformatf("%s busy e49", tag), 48'(busy), 48'd0);
                check($sformatf("%s g_out", tag), g_out, exp_g);
                check($sformatf("%s dbz", tag), 48'(dbz), 48'(exp_dbz));
            end else begin
                check($sformatf("%s done e50", tag), 48'(done), 48'd0);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        g_in         = '0;
        tau          = '0;
        delta_t      = '0;
        weight_valid = 1'b0;
        weight       = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst g_out", g_out, 48'd0);
        check("rst done", 48'(done), 48'd0);
        check("rst busy", 48'(busy), 48'd0);
        check("rst dbz", 48'(dbz), 48'd0);

        run_update("t1", 48'h0001_0000_0000, 16'd10, 4'd8, -1, '0, -1, '0, -1, '0,
                   48'h0000_F333_3334, 1'b0);
        run_update("t2", 48'hFFFF_0000_0000, 16'd10, 4'd8, -1, '0, -1, '0, -1, '0,
                   48'hFFFF_0CCC_CCCC, 1'b0);
        run_update("t3a", 48'h0, 16'd5, 4'd3, 0, 48'h0000_4000_0000, 20, 48'h0000_4000_0000,
                   49, 48'h0000_1000_0000, 48'h0000_8000_0000, 1'b0);
        run_update("t3b", 48'h0, 16'd5, 4'd0, -1, '0, -1, '0, -1, '0,
                   48'h0000_1000_0000, 1'b0);
        run_update("t4", 48'h0001_0000_0000, 16'd0, 4'd8, 7, 48'h0000_4000_0000, -1, '0, -1, '0,
                   48'h0001_4000_0000, 1'b1);

        // Start, ignored re-Start at edge 10, reset at edge 20 with a weight pending in Acc.
        for (int e = 0; e <= 20; e++) begin
            start        = (e == 0) || (e == 10);
            reset        = (e == 20);
            g_in         = (e == 10) ? 48'h0003_0000_0000 : 48'h0001_0000_0000;
            tau          = 16'd10;
            delta_t      = 4'd8;
            weight_valid = (e == 5);
            weight       = 48'h0000_4000_0000;
            tick();
            start        = 1'b0;
            reset        = 1'b0;
            weight_valid = 1'b0;
            if (e == 10) check("t5 busy e10", 48'(busy), 48'd1);
        end
        check("t5 rst g_out", g_out, 48'd0);
        check("t5 rst busy", 48'(busy), 48'd0);
        check("t5 rst done", 48'(done), 48'd0);
        check("t5 rst dbz", 48'(dbz), 48'd0);
        for (int e = 21; e <= 80; e++) begin
            tick();
            check($sformatf("t5 no done e%0d", e), 48'(done), 48'd0);
        end
        run_update("t5r", 48'h0001_0000_0000, 16'd10, 4'd8, -1, '0, -1, '0, -1, '0,
                   48'h0000_F333_3334, 1'b0);

        run_update("t6", 48'h1234_5678_9ABC, 16'd7, 4'd0, -1, '0, -1, '0, -1, '0,
                   48'h1234_5678_9ABC, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conductance_decay_unit.md
Name: conductance_decay_unit

Overview:
Sequential producer of the excitatory/inhibitory conductance g that the postsynaptic current units consume.
Per neuron update, it computes g_next = g - (g*DeltaT)/Tau + sum(synaptic weights received).
The division uses a serial restoring divider, trading latency for area.
It sits between the synaptic weight fetch path and the EPSC/IPSC current units, in the neuron update pipeline.

Parameters:
INTEGER_WIDTH, 16, integer bits of fixed-point format
DATA_WIDTH_FRAC, 32, fractional bits of fixed-point format
DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, total signed Q16.32 word width
DELTAT_WIDTH, 4, width of DeltaT; unsigned, all bits fractional (value = DeltaT/2^DELTAT_WIDTH)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  begin update; sampled only in IDLE
gIn  in  DATA_WIDTH  signed present conductance
Tau  in  INTEGER_WIDTH  signed integer time constant; must be >0
DeltaT  in  DELTAT_WIDTH  unsigned fractional timestep
WeightValid  in  1  qualifies Weight this cycle
Weight  in  DATA_WIDTH  signed synaptic weight to add
gOut  out  DATA_WIDTH  signed updated conductance, registered
Done  out  1  one-cycle pulse: gOut valid
Busy  out  1  high while an update is in flight
DivByZero  out  1  registered with Done; Tau<=0 in this update

Behaviour:
- Reset (synchronous, active-high, any state including mid-divide):
  - state to IDLE
  - gOut=0, Done=0, Busy=0, DivByZero=0
  - weight accumulator Acc=0, divider registers cleared
- States and transitions:
  - IDLE -> MULT on Start.
  - MULT -> DIV after 1 cycle.
  - DIV lasts exactly DATA_WIDTH cycles.
  - DIV -> DONE.
  - DONE -> IDLE after 1 cycle.
- Start handling:
  - Start edge (edge 0) latches gIn, Tau, DeltaT; Busy=1 from edge 0.
  - Start while Busy or in DONE is ignored; no queueing.
- Latency: gOut updated, Done=1 and Busy=0 after edge DATA_WIDTH+1 (49 with defaults); Done holds exactly one cycle.
- MULT:
  - DeltaT_ext = {INTEGER_WIDTH zeros, DeltaT, DATA_WIDTH_FRAC-DELTAT_WIDTH zeros}.
  - Full signed product P = gIn*DeltaT_ext (2*DATA_WIDTH bits).
  - Decay = P[DATA_WIDTH+DATA_WIDTH_FRAC-1 : DATA_WIDTH_FRAC]; no overflow possible since DeltaT<1.
- DIV:
  - Restoring division of |Decay| by Tau, one quotient bit per cycle, MSB first.
  - Result is Q16.32 because Tau is integer.
  - Sign of Decay reapplied at the end; truncation toward zero.
- Tau<=0: divider skipped (still DATA_WIDTH cycles, latency constant), quotient=0, DivByZero=1 with Done.
- Output: gOut = gIn - Quotient + Acc, DATA_WIDTH two's-complement wrap, no saturation.
- Weight accumulation:
  - Every edge with WeightValid=1 adds Weight into Acc (wrap), in any state.
  - Acc folded into gOut at the Done-producing edge; Acc cleared on that same edge.
  - A weight sampled on that same edge goes into the fresh Acc for the next update; never lost or doubled.
  - Weights arriving in IDLE persist until the next update.
- DivByZero cleared at next Start edge.

Test Plan:
1. gIn=48'h0001_0000_0000 (1.0), DeltaT=4'b1000 (0.5), Tau=10, Start pulse -> Done exactly at edge 49, gOut=48'h0000_F333_3334, DivByZero=0, Busy high edges 0..48.
2. gIn=48'hFFFF_0000_0000 (-1.0), DeltaT=8, Tau=10 -> gOut=48'hFFFF_0CCC_CCCC (truncation toward zero).
3. Weight accumulation:
   - Setup: gIn=0, Tau=5, DeltaT=3; WeightValid with Weight=48'h0000_4000_0000 on edges 0 and 20.
   - Third weight of 48'h0000_1000_0000 on edge 49.
   - Result: first gOut=48'h0000_8000_0000; next update with gIn=0, DeltaT=0 yields 48'h0000_1000_0000.
4. Tau=0, gIn=1.0, DeltaT=8, one weight 0.25 -> Done at edge 49, DivByZero=1, gOut=48'h0001_4000_0000.
5. Start at edge 0, Start re-pulsed at edge 10, Reset at edge 20 -> no second Done from the edge-10 Start. After edge 20: gOut=0, Busy=0, Done=0, Acc=0. Case 1 re-run afterwards gives identical result.
6. DeltaT=0, gIn=48'h1234_5678_9ABC, Tau=7 -> gOut=gIn unchanged, Done at edge 49.
